// File: rtl/fetch_unit_if.sv
// Program-memory fetch bus: the fetch unit issues a registered address/request,
// memory answers with read data qualified by mem_valid.
interface fetch_unit_if #(
    parameter int PC_WIDTH = 8,
    parameter int DATA_W   = 16
);
    logic [PC_WIDTH-1:0] mem_addr;
    logic                mem_req;
    logic [DATA_W-1:0]   mem_rdata;
    logic                mem_valid;

    modport master (output mem_addr, output mem_req, input mem_rdata, input mem_valid);
    modport slave  (input mem_addr, input mem_req, output mem_rdata, output mem_valid);
endinterface

// File: rtl/fetch_unit.sv
// PC + instruction-fetch stage: fetches one word per instruction, presents it to
// the decoder for a single EXEC cycle, then applies jump/skip to form the next PC.
module fetch_unit #(
    parameter int                           PC_WIDTH          = 8,
    parameter int                           PROGRAM_DataWidth = 16,
    parameter logic [PROGRAM_DataWidth-1:0] NOP_WORD          = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    fetch_unit_if.master                 mem_bus,
    output logic [PROGRAM_DataWidth-1:0] instruction,
    output logic                         instr_valid,
    input  logic                         cnt_wr_en,
    input  logic [PC_WIDTH-1:0]          literal_adr,
    input  logic                         skip,
    input  logic                         halt,
    output logic [PC_WIDTH-1:0]          pc,
    output logic                         halted
);

    typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALTED} state_t;

    state_t                         state;
    logic [PROGRAM_DataWidth-1:0]   ir;
    logic                           req;
    logic [PC_WIDTH-1:0]            addr;
    logic [PC_WIDTH-1:0]            pc_next;

    assign mem_bus.mem_req  = req;
    assign mem_bus.mem_addr = addr;

    // Decoder sees a NOP outside EXEC so it never raises a stray write enable.
    assign instruction = instr_valid ? ir : NOP_WORD;

    // Jump wins over skip; arithmetic wraps naturally at PC_WIDTH bits.
    always_comb begin
        pc_next = pc + PC_WIDTH'(1);
        if (cnt_wr_en)
            pc_next = literal_adr;
        else if (skip)
            pc_next = pc + PC_WIDTH'(2);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= '0;
            req         <= 1'b0;
            addr        <= '0;
            ir          <= NOP_WORD;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state <= FETCH;
                    req   <= 1'b1;
                    addr  <= pc;
                end
                FETCH: begin
                    if (req && mem_bus.mem_valid) begin
                        ir          <= mem_bus.mem_rdata;
                        instr_valid <= 1'b1;
                        req         <= 1'b0;
                        addr        <= '0;
                        state       <= EXEC;
                    end
                end
                EXEC: begin
                    instr_valid <= 1'b0;
                    pc          <= pc_next;
                    if (halt) begin
                        state  <= HALTED;
                        halted <= 1'b1;
                    end else begin
                        state <= FETCH;
                        req   <= 1'b1;
                        addr  <= pc_next;
                    end
                end
                HALTED: begin
                    if (!halt) begin
                        state  <= FETCH;
                        halted <= 1'b0;
                        req    <= 1'b1;
                        addr   <= pc;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: memory model with programmable latency, an action list
// driving the decoder side, and a queue of expected fetch addresses.
module tb_fetch_unit;

    localparam int          PW  = 8;
    localparam int          DW  = 16;
    localparam logic [15:0] NOP = 16'h0000;

    typedef struct {
        logic          jump;
        logic [PW-1:0] tgt;
        logic          skp;
        logic          hlt;
        int            nwait;
    } act_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] instruction;
    logic          instr_valid;
    logic          cnt_wr_en;
    logic [PW-1:0] literal_adr;
    logic          skip;
    logic          halt;
    logic [PW-1:0] pc;
    logic          halted;

    fetch_unit_if #(.PC_WIDTH(PW), .DATA_W(DW)) mem_bus ();

    fetch_unit #(.PC_WIDTH(PW), .PROGRAM_DataWidth(DW), .NOP_WORD(NOP)) dut (
        .clk         (clk),
        .reset       (reset),
        .mem_bus     (mem_bus),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .cnt_wr_en   (cnt_wr_en),
        .literal_adr (literal_adr),
        .skip        (skip),
        .halt        (halt),
        .pc          (pc),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    int            n_chk = 0;
    int            n_err = 0;
    logic [PW-1:0] addr_q[$];
    act_t          acts[$];
    logic [PW-1:0] cur_addr;
    logic [PW-1:0] hold_pc;
    int            req_cnt = 0;
    int            nwait = 0;
    int            cyc = 0;
    int            exec_cnt = 0;
    int            last_exec = 0;
    int            gap_exp = 0;
    bit            have_last = 0;
    bit            halt_req = 0;
    bit            exp_halted = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req"},    mem_bus.mem_req, 0);
        chk({tag, "_addr"},   mem_bus.mem_addr, 0);
        chk({tag, "_pc"},     pc, 0);
        chk({tag, "_ivalid"}, instr_valid, 0);
        chk({tag, "_instr"},  instruction, NOP);
        chk({tag, "_halted"}, halted, 0);
    endtask

    // One clock: sample outputs at the falling edge, drive inputs, then cross the rising edge.
    task automatic step();
        act_t          a;
        logic [PW-1:0] nxt;
        @(negedge clk);
        cyc++;
        chk("halted", halted, exp_halted);
        if (exp_halted) begin
            chk("halt_pc", pc, hold_pc);
            chk("halt_req", mem_bus.mem_req, 0);
            if (!halt_req) exp_halted = 0;
        end
        if (mem_bus.mem_req) begin
            if (req_cnt == 0) begin
                if (addr_q.size() == 0) chk("sb_empty", 1, 0);
                else cur_addr = addr_q.pop_front();
            end
            chk("fetch_addr", mem_bus.mem_addr, cur_addr);
            chk("fetch_pc", pc, cur_addr);
            mem_bus.mem_valid = (req_cnt >= nwait);
            mem_bus.mem_rdata = mem_bus.mem_valid ? 16'h0800 + 16'(mem_bus.mem_addr) : 16'hDEAD;
            req_cnt++;
        end else begin
            req_cnt = 0;
            mem_bus.mem_valid = $urandom_range(0, 1) == 1;
            mem_bus.mem_rdata = 16'hDEAD;
            chk("addr_idle", mem_bus.mem_addr, 0);
        end
        if (instr_valid) begin
            chk("exec_pc", pc, cur_addr);
            chk("exec_instr", instruction, 16'h0800 + 16'(cur_addr));
            if (have_last) chk("exec_gap", cyc - last_exec, gap_exp);
            a = '{jump: 1'b0, tgt: '0, skp: 1'b0, hlt: 1'b0, nwait: nwait};
            if (acts.size() != 0) a = acts.pop_front();
            cnt_wr_en   = a.jump;
            literal_adr = a.tgt;
            skip        = a.skp;
            halt        = a.hlt;
            halt_req    = a.hlt;
            nxt = a.jump ? a.tgt : a.skp ? cur_addr + 8'd2 : cur_addr + 8'd1;
            addr_q.push_back(nxt);
            nwait     = a.nwait;
            gap_exp   = nwait + 2;
            last_exec = cyc;
            have_last = !a.hlt;
            if (a.hlt) begin
                exp_halted = 1;
                hold_pc    = nxt;
            end
            exec_cnt++;
        end else begin
            chk("instr_nop", instruction, NOP);
            cnt_wr_en   = $urandom_range(0, 1) == 1;
            literal_adr = PW'($urandom);
            skip        = $urandom_range(0, 1) == 1;
            halt        = halt_req;
        end
        @(posedge clk);
    endtask

    task automatic run_execs(input int n);
        int tgt = exec_cnt + n;
        int b = 0;
        while (exec_cnt < tgt && b < 2000) begin
            step();
            b++;
        end
        if (exec_cnt < tgt) chk("exec_timeout", exec_cnt, tgt);
    endtask

    task automatic add(input logic j, input logic [PW-1:0] t, input logic s, input logic h, input int w);
        act_t a;
        a = '{jump: j, tgt: t, skp: s, hlt: h, nwait: w};
        acts.push_back(a);
    endtask

    initial begin
        int b;
        reset = 1'b1;
        cnt_wr_en = 0; literal_adr = '0; skip = 0; halt = 0;
        mem_bus.mem_valid = 0; mem_bus.mem_rdata = '0;
        // Execution plan, one entry per EXEC in order (pc noted on the right).
        add(0, 8'h00, 0, 0, 0);  // 0x00
        add(0, 8'h00, 0, 0, 0);  // 0x01
        add(0, 8'h00, 0, 0, 0);  // 0x02
        add(0, 8'h00, 0, 1, 0);  // 0x03 halt -> 0x04
        add(0, 8'h00, 0, 0, 0);  // 0x04
        add(1, 8'h40, 1, 0, 0);  // 0x05 jump beats skip
        add(1, 8'h10, 0, 0, 0);  // 0x40
        add(0, 8'h00, 1, 0, 0);  // 0x10 skip -> 0x12
        add(1, 8'hFF, 0, 0, 0);  // 0x12
        add(0, 8'h00, 0, 0, 0);  // 0xFF -> 0x00
        add(1, 8'hFE, 0, 0, 0);  // 0x00
        add(0, 8'h00, 1, 0, 0);  // 0xFE skip -> 0x00
        add(1, 8'hFF, 0, 0, 0);  // 0x00
        add(0, 8'h00, 1, 0, 3);  // 0xFF skip -> 0x01, slow memory from here
        add(0, 8'h00, 0, 0, 3);  // 0x01
        add(0, 8'h00, 0, 0, 3);  // 0x02
        add(0, 8'h00, 0, 0, 3);  // 0x03
        addr_q.push_back(8'h00);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("rst");
        reset = 1'b0;

        run_execs(4);
        repeat (10) step();
        halt_req = 0;
        run_execs(13);

        b = 0;
        do begin
            step();
            b++;
        end while (req_cnt != 1 && b < 50);
        chk("mid_fetch_found", req_cnt, 1);

        @(negedge clk);
        reset = 1'b1;
        #1;
        chk_reset_vals("rst_async");
        mem_bus.mem_valid = 1'b1;
        mem_bus.mem_rdata = 16'hBEEF;
        @(posedge clk);
        @(negedge clk);
        chk_reset_vals("rst_hold");
        reset = 1'b0;
        mem_bus.mem_valid = 1'b0;
        addr_q.delete();
        addr_q.push_back(8'h00);
        acts.delete();
        req_cnt = 0;
        have_last = 0;
        run_execs(2);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
